// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared sizes, states and memory geometry for the data-memory controller
package dmem_ctrl_pkg;
  localparam int DEPTH = 32;
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;
endpackage

// File: rtl/dmem_size_ext.sv
// dmem_size_ext: truncates data to byte/half/word/double and zero-extends it back to full width
module dmem_size_ext
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  always_comb
    dout = size == SZ_B ? {{(DATA_W-8){1'b0}}, din[7:0]} :
           size == SZ_H ? {{(DATA_W-16){1'b0}}, din[15:0]} :
           size == SZ_W ? {{(DATA_W-32){1'b0}}, din[31:0]} : din;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: 2-port arbiter and sequencer for the 32x64 single-port data SRAM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state;
  size_e             lat_size;
  logic              lat_we, lat_port, win, in_range;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, ld_data;
`ifdef DMEM_ARB_RR_EN
  logic ptr;
  assign win = p1_req && (!p0_req || ptr);
  always_ff @(posedge clk)
    ptr <= reset ? 1'b0 : (state == IDLE && (p0_req || p1_req)) ? !win : ptr;
`else
  assign win = !p0_req;
`endif
  assign in_range  = lat_addr[ADDR_W-1:IDX_W] == '0;
  assign mem_en    = state == ISSUE && in_range;
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr[IDX_W-1:0];
  assign p0_done   = state == RESP && !lat_port;
  assign p1_done   = state == RESP && lat_port;
  dmem_size_ext #(.DATA_W(DATA_W)) st_ext (.size(lat_size), .din(lat_wdata), .dout(mem_wdata));
  dmem_size_ext #(.DATA_W(DATA_W)) ld_ext (.size(lat_size), .din(mem_rdata), .dout(ld_data));
  // Losing requester's fields are only sampled here, in IDLE, once it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_size  <= SZ_B;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (p0_req || p1_req) begin
          state     <= ISSUE;
          lat_port  <= win;
          lat_we    <= win ? p1_we : p0_we;
          lat_size  <= size_e'(win ? p1_size : p0_size);
          lat_addr  <= win ? p1_addr : p0_addr;
          lat_wdata <= win ? p1_wdata : p0_wdata;
        end
        ISSUE: begin
          state <= (in_range && !lat_we) ? WAIT_RD : RESP;
          if (!in_range || lat_we) begin
            rsp_rdata <= '0;
            rsp_err   <= !in_range;
          end
        end
        WAIT_RD: begin
          state     <= RESP;
          rsp_rdata <= ld_data;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: transaction-level model with per-cycle compare plus directed literal checks
module tb_dmem_access_ctrl;
  logic clk = 0, reset = 1;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [1:0] p0_size = 0, p1_size = 0;
  logic [63:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic p0_done, p1_done, rsp_err, mem_en, mem_we;
  logic [63:0] rsp_rdata, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic [4:0] mem_addr;
  int errors = 0, checks = 0, cyc = 0, pref = 0;
  logic [63:0] sram [32];
  logic [63:0] ref_mem [32];
  bit exp_d0[int], exp_d1[int], exp_en[int], exp_we[int], exp_er[int];
  logic [4:0] exp_ad[int];
  logic [63:0] exp_wd[int], exp_rd[int];

  dmem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_done(p1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM stub: synchronous write, read data valid the cycle after the access
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] sz_mask(input logic [1:0] size);
    return size == 0 ? 64'hFF : size == 1 ? 64'hFFFF : size == 2 ? 64'hFFFF_FFFF : '1;
  endfunction

  // Transaction seen in cycle n: schedules expected SRAM access and done; returns latency.
  function automatic int model(input int port, input bit we, input logic [1:0] size,
                               input logic [63:0] addr, input logic [63:0] wd, input int n);
    bit err = addr >= 32;
    int lat = (err || we) ? 2 : 3;
    if (!err) begin
      exp_en[n+1] = 1;
      exp_we[n+1] = we;
      exp_ad[n+1] = addr[4:0];
      exp_wd[n+1] = wd & sz_mask(size);
    end
    if (port == 0) exp_d0[n+lat] = 1;
    else exp_d1[n+lat] = 1;
    exp_er[n+lat] = err;
    exp_rd[n+lat] = (err || we) ? 64'h0 : ref_mem[addr[4:0]] & sz_mask(size);
    if (we && !err) ref_mem[addr[4:0]] = wd & sz_mask(size);
    pref = 1 - port;
    return lat;
  endfunction

  always @(negedge clk) begin
    chk("p0_done", p0_done, 64'(exp_d0.exists(cyc)));
    chk("p1_done", p1_done, 64'(exp_d1.exists(cyc)));
    chk("mem_en", mem_en, 64'(exp_en.exists(cyc)));
    if (exp_en.exists(cyc)) begin
      chk("mem_we", mem_we, 64'(exp_we[cyc]));
      chk("mem_addr", 64'(mem_addr), 64'(exp_ad[cyc]));
      if (exp_we[cyc]) chk("mem_wdata", mem_wdata, exp_wd[cyc]);
    end
    if (exp_d0.exists(cyc) || exp_d1.exists(cyc)) begin
      chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
      chk("rsp_err", 64'(rsp_err), 64'(exp_er[cyc]));
    end
  end

  task automatic xact(input int port, input bit we, input logic [1:0] size, input logic [63:0] addr,
                      input logic [63:0] wd, output int lat, output logic [63:0] rd, output logic er);
    int n;
    bit seen = 0;
    @(posedge clk); #1;
    if (port == 0) begin p0_req = 1; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wd; end
    else begin p1_req = 1; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wd; end
    n = cyc;
    void'(model(port, we, size, addr, wd, n));
    lat = -1; rd = 'x; er = 'x;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (port == 0 ? p0_done : p1_done) begin seen = 1; lat = cyc - n; rd = rsp_rdata; er = rsp_err; end
    end
    chk("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
  endtask

  initial begin
    int lat, n, cnt, w;
    logic [63:0] rd;
    logic er;
    logic [3:0] seq;
    for (int i = 0; i < 32; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_done", 64'({p0_done, p1_done}), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 64'(rsp_err), 0);
    @(posedge clk); #1 reset = 0;

    xact(0, 1, 3, 3, 64'hDEADBEEF_CAFEF00D, lat, rd, er);
    chk("st_d_lat", lat, 2); chk("st_d_err", 64'(er), 0);
    chk("st_d_sram", sram[3], 64'hDEADBEEF_CAFEF00D);
    xact(0, 0, 0, 3, 0, lat, rd, er);
    chk("ld_b_lat", lat, 3); chk("ld_b_rd", rd, 64'h0D);
    xact(0, 0, 2, 3, 0, lat, rd, er);
    chk("ld_w_rd", rd, 64'hCAFEF00D);
    xact(0, 0, 3, 31, 0, lat, rd, er);
    chk("ld_31_err", 64'(er), 0); chk("ld_31_lat", lat, 3);
    xact(0, 1, 0, 32, 64'hFF, lat, rd, er);
    chk("st_32_err", 64'(er), 1); chk("st_32_lat", lat, 2);
    xact(0, 0, 3, 64'h1_0000_0003, 0, lat, rd, er);
    chk("ld_hi_err", 64'(er), 1); chk("ld_hi_rd", rd, 0);
    xact(1, 1, 1, 5, 64'h1234_5678, lat, rd, er);
    chk("st_h_sram", sram[5], 64'h5678);
    xact(1, 0, 3, 5, 0, lat, rd, er);
    chk("ld_h_rd", rd, 64'h5678);
    xact(1, 0, 3, 40, 0, lat, rd, er);
    chk("ld_40_lat", lat, 2); chk("ld_40_err", 64'(er), 1); chk("ld_40_rd", rd, 0);

    // contested requests, both held across four grants
    @(posedge clk); #1;
    p0_req = 1; p0_we = 1; p0_size = 0; p0_addr = 7; p0_wdata = 64'h1111_2222_3333_44AB;
    p1_req = 1; p1_we = 1; p1_size = 2; p1_addr = 8; p1_wdata = 64'hAAAA_BBBB_CCDD_EEFF;
    n = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      w = pref;
`else
      w = 0;
`endif
      n += model(w, 1, w ? p1_size : p0_size, w ? p1_addr : p0_addr, w ? p1_wdata : p0_wdata, n) + 1;
    end
    cnt = 0; seq = 0;
    for (int i = 0; i < 30 && cnt < 4; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) begin seq[cnt] = p1_done; cnt++; end
    end
    chk("contest_cnt", cnt, 4);
`ifdef DMEM_ARB_RR_EN
    chk("contest_seq", 64'(seq), 64'b1010);
`else
    chk("contest_seq", 64'(seq), 64'b0000);
`endif
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;

    xact(0, 0, 3, 3, 0, lat, rd, er);
    chk("ld_d_rd", rd, 64'hDEADBEEF_CAFEF00D);

    // reset during WAIT_RD aborts the load
    @(posedge clk); #1;
    p0_req = 1; p0_we = 0; p0_size = 3; p0_addr = 3;
    n = cyc;
    exp_en[n+1] = 1; exp_we[n+1] = 0; exp_ad[n+1] = 3;
    @(posedge clk); @(posedge clk); #1;
    reset = 1; p0_req = 0;
    @(posedge clk); #1;
    reset = 0; pref = 0;
    @(negedge clk);
    chk("abort_mem_en", 64'(mem_en), 0);
    chk("abort_done", 64'({p0_done, p1_done}), 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_addr", 64'(mem_addr), 0);
    chk("abort_wdata", mem_wdata, 0);
    xact(0, 0, 0, 5, 0, lat, rd, er);
    chk("post_rst_lat", lat, 3); chk("post_rst_rd", rd, 64'h78);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencing controller and 2-way arbiter for the 32-entry x 64-bit data memory.
- Port 0: load/store stage. Port 1: debug/DMA loader.
- Owns the single-port synchronous SRAM interface, applies byte/half/word/double size rules, range-checks addresses and returns one-cycle completion pulses.

Parameters:
DATA_W, 64, data width of memory entries and ports
ADDR_W, 64, requester address width (doubleword index)
DEPTH, 32, number of memory entries
IDX_W, 5, SRAM index width, equal to clog2(DEPTH)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request; held with its fields until p0_done
p0_we  in  1  1 = store, 0 = load
p0_size  in  2  00 byte, 01 half, 10 word, 11 double
p0_addr  in  ADDR_W  doubleword index
p0_wdata  in  DATA_W  store data
p0_done  out  1  one-cycle completion pulse
p1_req, p1_we, p1_size, p1_addr, p1_wdata, p1_done  same as port 0, for port 1
rsp_rdata  out  DATA_W  load result, zero-extended; valid while any done=1
rsp_err  out  1  address out of range; valid while any done=1
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  IDX_W  SRAM index
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer at port 0; request latch cleared.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any req is high, arbitrate, latch the winner's we/size/addr/wdata/port id, go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration (base build): port 0 has fixed priority over port 1.
- ISSUE:
  - In range (addr < DEPTH): mem_en=1, mem_we=latched we, mem_addr=addr[IDX_W-1:0], mem_wdata=size-truncated wdata zero-extended to 64 bits (a byte store writes {56'b0, wdata[7:0]}).
  - Next state: WAIT_RD for a load, RESP for a store.
  - Out of range (addr >= DEPTH, any upper bit set): no mem_en, error flag set, go to RESP.
- WAIT_RD: capture mem_rdata, mask it to size (zero-extend), go to RESP.
- RESP: winner's done=1 for exactly one cycle; rsp_rdata/rsp_err driven (rsp_rdata=0 for stores and errors); go to IDLE.
- rsp_rdata and rsp_err hold their value until the next RESP.
- Latency, request-seen cycle to done: store 2 cycles, load 3 cycles, error 2 cycles.
- Back-to-back: a requester holding req in the cycle after done is re-arbitrated as a new request. Requesters deassert on done.
- mem_en is high in at most one cycle per transaction; never two accesses in flight.
- Fields of a waiting (losing) requester are not sampled until it wins.
- Simultaneous req in IDLE: one winner; the loser waits with no done.
- Reset mid-operation: transaction aborted, no done issued, mem_en=0 from the next cycle.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. Pointer moves to the other port after each grant; only contested requests consult it.
- Undefined: fixed priority, port 0 over port 1; pointer logic absent.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - state_e enum (IDLE, ISSUE, WAIT_RD, RESP)
  - localparams DEPTH and IDX_W
- One sub-module, dmem_size_ext: combinational zero-extend/truncate by size, used for both store data and load data.

Test Plan:
- p0 store double, addr 3, wdata 64'hDEADBEEF_CAFEF00D -> mem_we=1 at idx 3 in cycle +1; p0_done in cycle +2; rsp_err=0.
- p0 load byte, addr 3 (entry holds 64'hDEADBEEF_CAFEF00D) -> p0_done at cycle +3; rsp_rdata=64'h0D.
- p1 store half of 64'h1234_5678 at addr 5, then p1 load double at addr 5 -> rsp_rdata=64'h5678.
- p1 load at addr 40 -> no mem_en; p1_done at +2; rsp_err=1; rsp_rdata=0.
- p0 and p1 req in the same cycle, both held for 4 transactions:
  - without DMEM_ARB_RR_EN: all done pulses go to p0 while p0_req stays high;
  - with DMEM_ARB_RR_EN: done pulses alternate p0, p1, p0, p1.
- reset asserted during WAIT_RD -> no done; all outputs 0 next cycle; a following p0 load completes normally in 3 cycles.
